// File: rtl/obuf_tag_sync_if.sv
// Tag-sync bus bundle: controller tag stream, per-slot handshakes and stage done/ready.
// The err signal exists only when OBUF_TAG_SYNC_ERR_EN is defined.
interface obuf_tag_sync_if #(
  parameter int NUM_TAG = 2,
  parameter int TAG_W   = 1
);
  logic               tag_req;
  logic               tag_reuse;
  logic               tag_flush;
  logic               tag_ready;
  logic               drain;
  logic               drain_done;
  logic [NUM_TAG-1:0] slot_tag_req;
  logic [NUM_TAG-1:0] slot_tag_reuse;
  logic [NUM_TAG-1:0] slot_tag_flush;
  logic [NUM_TAG-1:0] slot_tag_free;
  logic [NUM_TAG-1:0] slot_ldmem_ready;
  logic [NUM_TAG-1:0] slot_compute_ready;
  logic [NUM_TAG-1:0] slot_stmem_ready;
  logic [NUM_TAG-1:0] slot_next_compute;
  logic               ldmem_tag_done;
  logic               compute_tag_done;
  logic               stmem_tag_done;
  logic [NUM_TAG-1:0] slot_ldmem_done;
  logic [NUM_TAG-1:0] slot_compute_done;
  logic [NUM_TAG-1:0] slot_stmem_done;
  logic [TAG_W-1:0]   ldmem_tag;
  logic [TAG_W-1:0]   compute_tag;
  logic [TAG_W-1:0]   stmem_tag;
  logic               ldmem_ready;
  logic               compute_ready;
  logic               stmem_ready;
`ifdef OBUF_TAG_SYNC_ERR_EN
  logic               err;
`endif

  modport master (
    output tag_req, tag_reuse, tag_flush, drain,
    output slot_tag_free, slot_ldmem_ready, slot_compute_ready, slot_stmem_ready,
    output slot_next_compute, ldmem_tag_done, compute_tag_done, stmem_tag_done,
    input  tag_ready, drain_done, slot_tag_req, slot_tag_reuse, slot_tag_flush,
    input  slot_ldmem_done, slot_compute_done, slot_stmem_done,
    input  ldmem_tag, compute_tag, stmem_tag, ldmem_ready, compute_ready, stmem_ready
`ifdef OBUF_TAG_SYNC_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  tag_req, tag_reuse, tag_flush, drain,
    input  slot_tag_free, slot_ldmem_ready, slot_compute_ready, slot_stmem_ready,
    input  slot_next_compute, ldmem_tag_done, compute_tag_done, stmem_tag_done,
    output tag_ready, drain_done, slot_tag_req, slot_tag_reuse, slot_tag_flush,
    output slot_ldmem_done, slot_compute_done, slot_stmem_done,
    output ldmem_tag, compute_tag, stmem_tag, ldmem_ready, compute_ready, stmem_ready
`ifdef OBUF_TAG_SYNC_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/obuf_tag_sync.sv
// Tag sequencer for NUM_TAG output-buffer slots: allocation, per-stage round-robin
// pointers, done demux and drain FSM. Define OBUF_TAG_SYNC_ERR_EN for a sticky err flag.
//
// state | meaning
// RUN   | normal operation, allocation allowed
// FLUSH | one cycle, flush every occupied slot
// WAIT  | wait for all slots free, then pulse drain_done
module obuf_tag_sync #(
  parameter int NUM_TAG = 2,
  parameter int TAG_W   = 1
) (
  input  logic            clk,
  input  logic            reset,
  obuf_tag_sync_if.slave  bus
);
  localparam int OCC_W = $clog2(NUM_TAG + 1);

  typedef enum logic [1:0] {RUN, FLUSH, WAIT} state_t;

  state_t             state;
  logic [TAG_W-1:0]   alloc_ptr, last_ptr, ld_ptr, cmp_ptr, st_ptr;
  logic [OCC_W-1:0]   occ, occ_next, rel_cnt;
  logic [OCC_W:0]     occ_sum;
  logic [NUM_TAG-1:0] free_q, free_rise;
  logic [TAG_W-1:0]   tgt_ptr;
  logic               alloc_ok;
  logic               all_free;

  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(NUM_TAG - 1)) ? '0 : p + TAG_W'(1);
  endfunction

  function automatic logic [NUM_TAG-1:0] onehot(input logic [TAG_W-1:0] p);
    return NUM_TAG'(1) << p;
  endfunction

  assign all_free      = &bus.slot_tag_free;
  assign bus.tag_ready = (state == RUN) && (occ < OCC_W'(NUM_TAG)) && bus.slot_tag_free[alloc_ptr];
  assign alloc_ok      = bus.tag_req && bus.tag_ready;
  // A reuse/flush arriving with an accepted request belongs to the new slot.
  assign tgt_ptr       = alloc_ok ? alloc_ptr : last_ptr;

  assign bus.slot_tag_req   = alloc_ok      ? onehot(alloc_ptr) : '0;
  assign bus.slot_tag_reuse = bus.tag_reuse ? onehot(tgt_ptr)   : '0;
  assign bus.slot_tag_flush = (bus.tag_flush ? onehot(tgt_ptr) : '0)
                            | ((state == FLUSH) ? ~bus.slot_tag_free : '0);
  assign bus.drain_done     = (state == WAIT) && (occ == '0) && all_free;

  assign bus.slot_ldmem_done   = bus.ldmem_tag_done   ? onehot(ld_ptr)  : '0;
  assign bus.slot_compute_done = bus.compute_tag_done ? onehot(cmp_ptr) : '0;
  assign bus.slot_stmem_done   = bus.stmem_tag_done   ? onehot(st_ptr)  : '0;

  assign bus.ldmem_tag     = ld_ptr;
  assign bus.compute_tag   = cmp_ptr;
  assign bus.stmem_tag     = st_ptr;
  assign bus.ldmem_ready   = bus.slot_ldmem_ready[ld_ptr];
  assign bus.compute_ready = bus.slot_compute_ready[cmp_ptr];
  assign bus.stmem_ready   = bus.slot_stmem_ready[st_ptr];

  assign free_rise = bus.slot_tag_free & ~free_q;

  // Several slots may release in one cycle; count all of them, then saturate.
  always_comb begin
    rel_cnt = '0;
    for (int k = 0; k < NUM_TAG; k++) rel_cnt = rel_cnt + OCC_W'(free_rise[k]);
    occ_sum  = {1'b0, occ} + (OCC_W + 1)'(alloc_ok);
    occ_next = occ;
    if (occ_sum <= {1'b0, rel_cnt})
      occ_next = '0;
    else if ((occ_sum - {1'b0, rel_cnt}) > (OCC_W + 1)'(NUM_TAG))
      occ_next = OCC_W'(NUM_TAG);
    else
      occ_next = OCC_W'(occ_sum - {1'b0, rel_cnt});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      alloc_ptr <= '0;
      last_ptr  <= '0;
      ld_ptr    <= '0;
      cmp_ptr   <= '0;
      st_ptr    <= '0;
      occ       <= '0;
      free_q    <= bus.slot_tag_free;
    end else begin
      free_q <= bus.slot_tag_free;
      occ    <= occ_next;
      if (alloc_ok) begin
        last_ptr  <= alloc_ptr;
        alloc_ptr <= ptr_inc(alloc_ptr);
      end
      if (bus.ldmem_tag_done)             ld_ptr  <= ptr_inc(ld_ptr);
      if (bus.slot_next_compute[cmp_ptr]) cmp_ptr <= ptr_inc(cmp_ptr);
      if (bus.stmem_tag_done)             st_ptr  <= ptr_inc(st_ptr);
      case (state)
        RUN:     if (bus.drain) state <= FLUSH;
        FLUSH:   state <= WAIT;
        WAIT:    if (occ == '0 && all_free) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef OBUF_TAG_SYNC_ERR_EN
  logic err_q;
  assign bus.err = err_q;

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if ((bus.tag_req && !bus.tag_ready && state == RUN)
          || (bus.ldmem_tag_done && !bus.ldmem_ready)
          || (bus.compute_tag_done && !bus.compute_ready)
          || (bus.stmem_tag_done && !bus.stmem_ready)
          || ((bus.tag_reuse || bus.tag_flush) && occ == '0))
      err_q <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_obuf_tag_sync.sv
// Directed self-checking bench for obuf_tag_sync (NUM_TAG=2); err checks run
// only when OBUF_TAG_SYNC_ERR_EN is defined.
module tb_obuf_tag_sync;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  obuf_tag_sync_if #(.NUM_TAG(2), .TAG_W(1)) bus ();
  obuf_tag_sync #(.NUM_TAG(2), .TAG_W(1)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.tag_req = 0; bus.tag_reuse = 0; bus.tag_flush = 0; bus.drain = 0;
    bus.slot_tag_free = 2'b11;
    bus.slot_ldmem_ready = 2'b11; bus.slot_compute_ready = 2'b11; bus.slot_stmem_ready = 2'b11;
    bus.slot_next_compute = 2'b00;
    bus.ldmem_tag_done = 0; bus.compute_tag_done = 0; bus.stmem_tag_done = 0;
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst_slot_req",   32'(bus.slot_tag_req),   32'h0);
    chk("rst_slot_flush", 32'(bus.slot_tag_flush), 32'h0);
    chk("rst_drain_done", 32'(bus.drain_done),     32'h0);
    chk("rst_tags",       {29'd0, bus.ldmem_tag, bus.compute_tag, bus.stmem_tag}, 32'h0);
    chk("rst_tag_ready",  32'(bus.tag_ready),      32'h1);

    // First allocation goes to slot 0
    bus.tag_req = 1; settle();
    chk("alloc0_req", 32'(bus.slot_tag_req), 32'h1);
    tick(); bus.tag_req = 0; bus.slot_tag_free = 2'b10;
    bus.tag_reuse = 1; settle();
    chk("reuse_last0", 32'(bus.slot_tag_reuse), 32'h1);
    bus.tag_reuse = 0;

    // Second allocation to slot 1, then the bank is full
    bus.tag_req = 1; settle();
    chk("alloc1_ready", 32'(bus.tag_ready), 32'h1);
    chk("alloc1_req",   32'(bus.slot_tag_req), 32'h2);
    tick(); bus.slot_tag_free = 2'b00; settle();
    chk("full_ready", 32'(bus.tag_ready), 32'h0);
    chk("full_req",   32'(bus.slot_tag_req), 32'h0);
    bus.tag_req = 0;

    // Compute reuse passes do not advance compute_tag
    bus.compute_tag_done = 1; settle();
    chk("cmp_done_pass", 32'(bus.slot_compute_done), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("cmp_tag_hold", 32'(bus.compute_tag), 32'h0);
    end
    bus.slot_next_compute = 2'b01; settle();
    chk("cmp_done_final", 32'(bus.slot_compute_done), 32'h1);
    tick(); bus.compute_tag_done = 0; bus.slot_next_compute = 2'b00; settle();
    chk("cmp_tag_adv", 32'(bus.compute_tag), 32'h1);

    // ldmem and stmem demux and pointer advance
    bus.ldmem_tag_done = 1; bus.stmem_tag_done = 1; settle();
    chk("ld_done", 32'(bus.slot_ldmem_done), 32'h1);
    chk("st_done", 32'(bus.slot_stmem_done), 32'h1);
    tick(); bus.ldmem_tag_done = 0; bus.stmem_tag_done = 0;
    bus.slot_ldmem_ready = 2'b10; bus.slot_stmem_ready = 2'b01; settle();
    chk("ld_tag_adv",   32'(bus.ldmem_tag), 32'h1);
    chk("st_tag_adv",   32'(bus.stmem_tag), 32'h1);
    chk("ld_ready_sel", 32'(bus.ldmem_ready), 32'h1);
    chk("st_ready_sel", 32'(bus.stmem_ready), 32'h0);
    bus.slot_ldmem_ready = 2'b11; bus.slot_stmem_ready = 2'b11;

    // Slot 0 releases; ready reappears after the edge
    bus.slot_tag_free = 2'b01; settle();
    chk("rel_before", 32'(bus.tag_ready), 32'h0);
    tick();
    chk("rel_after", 32'(bus.tag_ready), 32'h1);

    // Request plus flush in the same cycle flushes the newly allocated slot (0)
    bus.tag_req = 1; bus.tag_flush = 1; settle();
    chk("reqflush_req",   32'(bus.slot_tag_req),   32'h1);
    chk("reqflush_flush", 32'(bus.slot_tag_flush), 32'h1);
    tick(); bus.tag_req = 0; bus.slot_tag_free = 2'b00; settle();
    chk("flush_last", 32'(bus.slot_tag_flush), 32'h1);
    bus.tag_flush = 0;

    // Drain with both slots occupied
    bus.drain = 1; tick(); bus.drain = 0; settle();
    chk("drain_flush",    32'(bus.slot_tag_flush), 32'h3);
    chk("drain_ready",    32'(bus.tag_ready),      32'h0);
    chk("drain_done_fl",  32'(bus.drain_done),     32'h0);
    tick();
    chk("wait_flush",     32'(bus.slot_tag_flush), 32'h0);
    bus.slot_tag_free = 2'b11; settle();
    chk("wait_done_busy", 32'(bus.drain_done), 32'h0);
    tick();
    chk("drain_done",     32'(bus.drain_done), 32'h1);
    tick();
    chk("drain_done_end", 32'(bus.drain_done), 32'h0);
    chk("run_ready",      32'(bus.tag_ready),  32'h1);

    // Drain with nothing occupied completes two cycles after the pulse
    bus.drain = 1; tick(); bus.drain = 0; settle();
    chk("empty_flush", 32'(bus.slot_tag_flush), 32'h0);
    chk("empty_ready", 32'(bus.tag_ready),      32'h0);
    chk("empty_done0", 32'(bus.drain_done),     32'h0);
    tick();
    chk("empty_done",  32'(bus.drain_done),     32'h1);
    tick();
    chk("empty_done2", 32'(bus.drain_done),     32'h0);

    // Reset while waiting in WAIT
    bus.tag_req = 1; settle();
    chk("alloc_s1", 32'(bus.slot_tag_req), 32'h2);
    tick(); bus.tag_req = 0; bus.slot_tag_free = 2'b01;
    bus.drain = 1; tick(); bus.drain = 0; settle();
    chk("drain_s1", 32'(bus.slot_tag_flush), 32'h2);
    tick(); settle();
    chk("wait_s1_busy", 32'(bus.drain_done), 32'h0);
    reset = 1; tick(); reset = 0; settle();
    chk("wrst_tags",  {29'd0, bus.ldmem_tag, bus.compute_tag, bus.stmem_tag}, 32'h0);
    chk("wrst_flush", 32'(bus.slot_tag_flush), 32'h0);
    chk("wrst_done",  32'(bus.drain_done),     32'h0);
    chk("wrst_ready", 32'(bus.tag_ready),      32'h1);
    bus.tag_req = 1; settle();
    chk("wrst_alloc", 32'(bus.slot_tag_req), 32'h1);
    bus.tag_req = 0;

`ifdef OBUF_TAG_SYNC_ERR_EN
    reset = 1; tick(); reset = 0; settle();
    chk("err_rst", 32'(bus.err), 32'h0);
    bus.slot_stmem_ready = 2'b00; bus.stmem_tag_done = 1;
    tick(); bus.stmem_tag_done = 0; bus.slot_stmem_ready = 2'b11; settle();
    chk("err_set", 32'(bus.err), 32'h1);
    tick(); tick();
    chk("err_sticky", 32'(bus.err), 32'h1);
    reset = 1; tick(); reset = 0; settle();
    chk("err_clr", 32'(bus.err), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
